oled_pixel_streamer: RTL
========================

OLED_PIXEL_STREAMER -- requirements
Module: oled_pixel_streamer

Interface
REQ-001 SHALL have parameter WIDTH, default 96, meaning pixels per row.
REQ-002 SHALL have parameter HEIGHT, default 64, meaning rows per frame.
REQ-003 SHALL have parameter PIXEL_LATENCY, default 2, meaning cycles from an x/y change until pixel_data is valid.
REQ-004 SHALL have parameter CLK_DIV, default 4, meaning basys_clk cycles per SCLK half-period (minimum 1).
REQ-005 SHALL have port basys_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port frame_start, input, 1 bit: single-cycle frame request.
REQ-008 SHALL have ports x and y, output, 7 bits each: current pixel coordinate presented to the drawing logic.
REQ-009 SHALL have port pixel_data, input, 16 bits: RGB565 colour for x/y, valid PIXEL_LATENCY cycles after x/y change.
REQ-010 SHALL have ports oled_sclk, oled_mosi, oled_cs_n and oled_dc, output, 1 bit each: serial link to the panel.
REQ-011 SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-012 SHALL have port frame_done, output, 1 bit: single-cycle pulse after the last pixel.

Function
REQ-013 States SHALL be IDLE, FETCH, SHIFT, NEXT and DONE.
REQ-014 IDLE: when frame_start=1, the block SHALL load x=0 and y=0, drive cs_n=0, dc=1, busy=1, and enter FETCH on the next cycle.
REQ-015 frame_start SHALL be ignored in every state except IDLE.
REQ-016 FETCH SHALL hold x/y stable for PIXEL_LATENCY+1 cycles, then capture pixel_data into a 16-bit shift register and enter SHIFT.
REQ-017 SHIFT SHALL transmit 16 bits MSB first, SPI mode 0 (SCLK idle low).
REQ-018 In SHIFT, each bit SHALL last 2*CLK_DIV cycles: SCLK low for CLK_DIV cycles with MOSI already valid, then high for CLK_DIV cycles.
REQ-019 MOSI SHALL change only while SCLK is low.
REQ-020 After bit 0 completes, the block SHALL enter NEXT for 1 cycle.
REQ-021 NEXT: if x<WIDTH-1, the block SHALL increment x and return to FETCH.
REQ-022 NEXT: otherwise, if y<HEIGHT-1, the block SHALL set x=0, increment y and return to FETCH.
REQ-023 NEXT: otherwise (last pixel), the block SHALL enter DONE.
REQ-024 Pixel pitch SHALL be (PIXEL_LATENCY+1) + 32*CLK_DIV + 1 cycles; 132 cycles with defaults.
REQ-025 DONE SHALL last 1 cycle with frame_done=1, cs_n=1, busy=0, x=0, y=0; the next state SHALL be IDLE.
REQ-026 A frame_start in the DONE cycle SHALL be ignored.
REQ-027 x SHALL never exceed WIDTH-1 and y SHALL never exceed HEIGHT-1; counters SHALL wrap only through NEXT.
REQ-028 oled_sclk SHALL be 0 in every state except SHIFT.
REQ-029 oled_dc SHALL be 1 whenever cs_n=0.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 When rst_n=0 at a clock edge, the block SHALL enter IDLE and set x=0, y=0, oled_sclk=0, oled_mosi=0, oled_cs_n=1, oled_dc=0, busy=0, frame_done=0 and shift register=0.
REQ-032 Reset mid-frame, including mid-bit, SHALL abort the frame without emitting frame_done; cs_n SHALL be high on the first cycle after the reset edge.

Structure
REQ-033 Panel geometry (96, 64), the RGB565 colour constants and the state encodings SHALL live in the shared package oled_pkg.
REQ-034 Bit serialisation (CLK_DIV divider, bit counter, 16-bit shift register) SHALL be a sub-module spi_shift16 with load/done handshake; the FSM and x/y counters SHALL stay in the top module.

Verification
REQ-035 Bench SHALL drive frame_start with pixel_data model = {x,y,2'b00} delayed 2 cycles -> first 16 MOSI bits = 16'h0000, second pixel = 16'h0200, cs_n low throughout.
REQ-036 Bench SHALL run a full frame with defaults -> frame_done exactly 6144*132+1 cycles after frame_start; 6144 words captured; last x=95, y=63.
REQ-037 Bench SHALL drive constant pixel_data=16'hFFE0 with CLK_DIV=1 -> SCLK period 2 cycles; MOSI pattern 11111111_11100000 per pixel; MOSI stable on every SCLK rising edge.
REQ-038 Bench SHALL pulse frame_start mid-frame and again in the DONE cycle -> no restart; pixel order unaffected.
REQ-039 Bench SHALL assert rst_n=0 during bit 7 of pixel (10,3) -> next cycle cs_n=1, sclk=0, busy=0, x=y=0; no frame_done; a fresh frame_start then restarts at (0,0).
REQ-040 Bench SHALL use WIDTH=4, HEIGHT=2 -> row wrap at x=3→0 with y 0→1; exactly 8 pixels, then frame_done.

Source files
------------

// File: rtl/oled_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// oled_pkg: panel geometry, RGB565 colours and streamer state encoding. Rev 1.0
// ------------------------------------------------------------------------
package oled_pkg;

  localparam int OLED_WIDTH  = 96;
  localparam int OLED_HEIGHT = 64;
  localparam int COORD_W     = 7;
  localparam int PIXEL_W     = 16;

  localparam logic [PIXEL_W-1:0] RGB565_BLACK  = 16'h0000;
  localparam logic [PIXEL_W-1:0] RGB565_WHITE  = 16'hFFFF;
  localparam logic [PIXEL_W-1:0] RGB565_RED    = 16'hF800;
  localparam logic [PIXEL_W-1:0] RGB565_GREEN  = 16'h07E0;
  localparam logic [PIXEL_W-1:0] RGB565_BLUE   = 16'h001F;
  localparam logic [PIXEL_W-1:0] RGB565_YELLOW = 16'hFFE0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SHIFT = 3'd2,
    ST_NEXT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_shift16.sv
`default_nettype none
// ------------------------------------------------------------------------
// spi_shift16: 16-bit MSB-first SPI mode-0 serialiser, CLK_DIV cycles per half-bit. Rev 1.0
// ------------------------------------------------------------------------
module spi_shift16
  import oled_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [PIXEL_W-1:0] data,
  output logic               sclk,
  output logic               mosi,
  output logic               done
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [PIXEL_W-1:0] r_shift;
  logic [DIV_W-1:0]   r_div;
  logic [3:0]         r_bit;
  logic               r_active;

  // MOSI is the register MSB, so it only moves on the high-to-low SCLK edge.
  assign mosi = r_shift[PIXEL_W-1];
  assign done = r_active & sclk & (r_div == DIV_LAST) & (r_bit == 4'd15);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift  <= '0;
      r_div    <= '0;
      r_bit    <= '0;
      r_active <= 1'b0;
      sclk     <= 1'b0;
    end else if (load) begin
      r_shift  <= data;
      r_div    <= '0;
      r_bit    <= '0;
      r_active <= 1'b1;
      sclk     <= 1'b0;
    end else if (r_active) begin
      if (r_div == DIV_LAST) begin
        r_div <= '0;
        if (!sclk) begin
          sclk <= 1'b1;
        end else begin
          sclk <= 1'b0;
          if (r_bit == 4'd15) begin
            r_active <= 1'b0;
          end else begin
            r_bit   <= r_bit + 4'd1;
            r_shift <= {r_shift[PIXEL_W-2:0], 1'b0};
          end
        end
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/oled_pixel_streamer.sv
`default_nettype none
// ------------------------------------------------------------------------
// oled_pixel_streamer: frame FSM and x/y raster scan feeding pixels to spi_shift16. Rev 1.0
// ------------------------------------------------------------------------
module oled_pixel_streamer
  import oled_pkg::*;
#(
  parameter int WIDTH         = OLED_WIDTH,
  parameter int HEIGHT        = OLED_HEIGHT,
  parameter int PIXEL_LATENCY = 2,
  parameter int CLK_DIV       = 4
) (
  input  logic               basys_clk,
  input  logic               rst_n,
  input  logic               frame_start,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  input  logic [PIXEL_W-1:0] pixel_data,
  output logic               oled_sclk,
  output logic               oled_mosi,
  output logic               oled_cs_n,
  output logic               oled_dc,
  output logic               busy,
  output logic               frame_done
);

  localparam int                 FETCH_W    = (PIXEL_LATENCY > 0) ? $clog2(PIXEL_LATENCY + 1) : 1;
  localparam logic [FETCH_W-1:0] FETCH_LAST = FETCH_W'(PIXEL_LATENCY);
  localparam logic [COORD_W-1:0] X_LAST     = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST     = COORD_W'(HEIGHT - 1);

  state_t             r_state, w_state_next;
  logic [FETCH_W-1:0] r_fetch_cnt, w_fetch_next;
  logic [COORD_W-1:0] w_x_next, w_y_next;
  logic               w_cs_n_next, w_dc_next, w_busy_next, w_done_next;
  logic               w_load, w_spi_done;

  spi_shift16 #(
    .CLK_DIV (CLK_DIV)
  ) u_spi (
    .clk   (basys_clk),
    .rst_n (rst_n),
    .load  (w_load),
    .data  (pixel_data),
    .sclk  (oled_sclk),
    .mosi  (oled_mosi),
    .done  (w_spi_done)
  );

  always_ff @(posedge basys_clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_fetch_cnt <= '0;
      x           <= '0;
      y           <= '0;
      oled_cs_n   <= 1'b1;
      oled_dc     <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_fetch_cnt <= w_fetch_next;
      x           <= w_x_next;
      y           <= w_y_next;
      oled_cs_n   <= w_cs_n_next;
      oled_dc     <= w_dc_next;
      busy        <= w_busy_next;
      frame_done  <= w_done_next;
    end
  end

  // Next-state and next-output logic; the register above makes every output a flop.
  always_comb begin
    w_state_next = r_state;
    w_fetch_next = r_fetch_cnt;
    w_x_next     = x;
    w_y_next     = y;
    w_cs_n_next  = oled_cs_n;
    w_dc_next    = oled_dc;
    w_busy_next  = busy;
    w_done_next  = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (frame_start) begin
          w_state_next = ST_FETCH;
          w_fetch_next = '0;
          w_x_next     = '0;
          w_y_next     = '0;
          w_cs_n_next  = 1'b0;
          w_dc_next    = 1'b1;
          w_busy_next  = 1'b1;
        end
      end
      ST_FETCH: begin
        // pixel_data for the current x/y is valid on the last hold cycle.
        if (r_fetch_cnt == FETCH_LAST) begin
          w_load       = 1'b1;
          w_state_next = ST_SHIFT;
        end else begin
          w_fetch_next = r_fetch_cnt + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_spi_done) w_state_next = ST_NEXT;
      end
      ST_NEXT: begin
        w_fetch_next = '0;
        if (x != X_LAST) begin
          w_x_next     = x + 7'd1;
          w_state_next = ST_FETCH;
        end else if (y != Y_LAST) begin
          w_x_next     = '0;
          w_y_next     = y + 7'd1;
          w_state_next = ST_FETCH;
        end else begin
          w_state_next = ST_DONE;
          w_x_next     = '0;
          w_y_next     = '0;
          w_cs_n_next  = 1'b1;
          w_dc_next    = 1'b0;
          w_busy_next  = 1'b0;
          w_done_next  = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
